serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Multi-cycle bit-serial add/subtract sequencer: owns one 1-bit full-adder stage
//  and steps it LSB-first over WIDTH bits, one bit per clock, with a carry register.
//  Area-cheap alternative to a parallel adder for non-critical ops (CSR/counter math).
//  Valid/ready on both the request and the result side; one operation in flight.
// PARAMETERS
//  WIDTH  32             operand/result width in bits, >=1
//  CNT_W  $clog2(WIDTH+1) bit counter width (derived; do not override)
// PORTS
//  clk          in   1      rising-edge clock; single clock domain
//  reset        in   1      synchronous, active-high reset
//  req_valid    in   1      request present on a/b/cin/sub
//  req_ready    out  1      block can accept a request (high only in IDLE)
//  a            in   WIDTH  operand A
//  b            in   WIDTH  operand B
//  cin          in   1      carry-in (ignored when sub=1)
//  sub          in   1      1: compute a-b (b inverted, carry-in forced 1)
//  res_valid    out  1      result outputs valid (high only in DONE)
//  res_ready    in   1      consumer accepts result
//  sum          out  WIDTH  result
//  cout         out  1      carry-out of MSB (sub: 1 = no borrow)
//  ovf          out  1      signed overflow = carry into MSB ^ carry out of MSB
//  busy         out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset: state=IDLE; sum=0, cout=0, ovf=0, res_valid=0, busy=0; req_ready=1 in the
//   cycle after reset deasserts. Reset wins over every other event, incl. mid-RUN
//   (operation aborted, no result produced).
//  FSM: IDLE -> RUN on req_valid&&req_ready; RUN -> DONE when cnt==WIDTH-1 at the
//   edge; DONE -> IDLE on res_ready. No other transitions.
//  Accept edge: opA<=a; opB<= sub ? ~b : b; carry<= sub ? 1 : cin; cnt<=0;
//   sum/cout/ovf cleared to 0.
//  RUN, each edge: s,c = FA(opA[0], opB[0], carry); sum<={s, sum[WIDTH-1:1]};
//   opA/opB shift right by 1; carry<=c; cnt<=cnt+1. On the edge with cnt==WIDTH-1:
//   cout<=c; ovf<=carry^c (carry = carry into MSB).
//  Latency: res_valid rises exactly WIDTH clocks after the accept edge
//   (WIDTH=1: one clock). Throughput: one op per WIDTH+2 clocks min.
//  DONE: sum/cout/ovf held stable while res_valid=1 && !res_ready (any length).
//   res_valid&&res_ready -> IDLE next edge; req_ready returns 1 only in IDLE, so
//   a req_valid seen in DONE is not accepted; no back-to-back op in the same cycle.
//  Inputs a/b/cin/sub/req_valid ignored outside IDLE; changes mid-RUN have no effect.
//  Arithmetic modulo 2^WIDTH; cnt never exceeds WIDTH-1; no X on outputs post-reset.
// STRUCTURE
//  Shared package: FSM state encoding (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
//   2'd3 illegal -> treated as IDLE) and the derived CNT_W expression.
//  One sub-module: fa_bit (combinational 1-bit full adder: s=a^b^ci,
//   co=a&b | ci&(a|b)); instantiated once. All state in serial_add_ctrl.
// TESTING (WIDTH=8)
//  a=0x0F,b=0x01,cin=0,sub=0 -> sum=0x10,cout=0,ovf=0; res_valid 8 clks after accept
//  a=0xFF,b=0x01,cin=0 -> sum=0x00,cout=1,ovf=0; a=0x7F,b=0x01 -> sum=0x80,ovf=1
//  sub=1,a=0x05,b=0x07 -> sum=0xFE,cout=0,ovf=0; sub=1,a=0x80,b=0x01 -> 0x7F,ovf=1
//  Backpressure: res_ready=0 for 5 clks in DONE -> outputs stable, req_ready=0,
//   req_valid pulses ignored; res_ready=1 -> IDLE next edge, req_ready=1
//  reset=1 on 3rd RUN clk -> next edge: res_valid=0,busy=0,sum=0,req_ready=1;
//   new op 0x12+0x34 then completes with sum=0x46 in 8 clks
//  WIDTH=1 build: a=1,b=1,cin=1 -> sum=1,cout=1,ovf=0; res_valid 1 clk after accept

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
//
// Contents: FSM state encoding and the bit-counter width helper.
package serial_add_ctrl_pkg;

  // 2'd3 is not a legal state; the sequencer recovers to IDLE if it ever appears.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width wide enough to hold 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Combinational 1-bit full adder, the single arithmetic stage of the sequencer.
// Latency: zero (pure combinational).
// Backpressure: n/a.
//
// Ports: a, b, ci (operand bits and carry-in) -> s (sum bit), co (carry-out).
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a | b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full adder stepped LSB-first over WIDTH bits.
// Latency: res_valid rises WIDTH clocks after the accept edge; one op in flight.
// Backpressure: req_ready only in IDLE; result held in DONE until res_ready.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake carrying a, b, cin, sub
//   res_valid/res_ready   result handshake carrying sum, cout, ovf
//   busy                  high while an operation is running or awaiting pickup
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_shift;

  fa_bit u_fa (
    .a  (opa[0]),
    .b  (opb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH steps the LSB-first bits line up.
  // Written as shift-then-overwrite so it stays legal for WIDTH=1.
  always_comb begin
    sum_shift            = sum >> 1;
    sum_shift[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      opa       <= '0;
      opb       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            // Subtraction is a + ~b + 1, so invert b and force the carry-in.
            opa       <= a;
            opb       <= sub ? ~b : b;
            carry     <= sub ? 1'b1 : cin;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            state     <= ST_RUN;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end

        ST_RUN: begin
          sum   <= sum_shift;
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= fa_co;
          if (cnt == CNT_LAST) begin
            // On the MSB step, carry holds the carry into the MSB.
            cout      <= fa_co;
            ovf       <= carry ^ fa_co;
            state     <= ST_DONE;
            res_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          if (res_ready) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: begin
          // Illegal encoding: fall back to a clean IDLE.
          state     <= ST_IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  // WIDTH=8 instance
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       busy;

  // WIDTH=1 instance
  logic       w1_req_valid = 1'b0;
  logic       w1_req_ready;
  logic [0:0] w1_a = '0;
  logic [0:0] w1_b = '0;
  logic       w1_cin = 1'b0;
  logic       w1_sub = 1'b0;
  logic       w1_res_valid;
  logic       w1_res_ready = 1'b0;
  logic [0:0] w1_sum;
  logic       w1_cout;
  logic       w1_ovf;
  logic       w1_busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (w1_req_valid),
    .req_ready (w1_req_ready),
    .a         (w1_a),
    .b         (w1_b),
    .cin       (w1_cin),
    .sub       (w1_sub),
    .res_valid (w1_res_valid),
    .res_ready (w1_res_ready),
    .sum       (w1_sum),
    .cout      (w1_cout),
    .ovf       (w1_ovf),
    .busy      (w1_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if ({req_ready, res_valid, busy, cout, ovf} !== 5'b10000 || sum !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_state: rdy/vld/busy/cout/ovf=%b sum=%h, want 10000 sum=00",
               {req_ready, res_valid, busy, cout, ovf}, sum);
    end
  endtask

  // Accepts one op, scrambles the inputs mid-run, then checks latency and result.
  task automatic do_op(input string name, input logic [7:0] ia, input logic [7:0] ib,
                       input logic icin, input logic isub, input logic [7:0] esum,
                       input logic ecout, input logic eovf);
    int lat;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_ready: req_ready=%b, want 1", name, req_ready);
    end
    a = ia; b = ib; cin = icin; sub = isub; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    a = ~ia; b = ~ib; cin = ~icin; sub = ~isub;
    tests_run++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_run: busy=%b req_ready=%b, want 1 0", name, busy, req_ready);
    end
    lat = 0;
    while (res_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    tests_run++;
    if (lat != 8) begin
      tests_failed++;
      $display("FAIL %s_latency: %0d clks, want 8", name, lat);
    end
    tests_run++;
    if (sum !== esum || cout !== ecout || ovf !== eovf) begin
      tests_failed++;
      $display("FAIL %s_result: sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, esum, ecout, eovf);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tests_run++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_release: rdy=%b vld=%b busy=%b, want 1 0 0",
               name, req_ready, res_valid, busy);
    end
  endtask

  task automatic test_add();
    do_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op("add_cin",   8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    do_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    do_op("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    int lat;
    a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      a = 8'hC3 + 8'(i); b = 8'h11; req_valid = (i % 2) == 0;
      tick();
      tests_run++;
      if (res_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1 ||
          sum !== 8'h10 || cout !== 1'b0 || ovf !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: vld=%b rdy=%b busy=%b sum=%h cout=%b ovf=%b, want 1 0 1 10 0 0",
                 i, res_valid, req_ready, busy, sum, cout, ovf);
      end
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tests_run++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: rdy=%b vld=%b busy=%b, want 1 0 0", req_ready, res_valid, busy);
    end
    // The DONE-phase req_valid pulses must not have started anything.
    tick();
    tests_run++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_no_accept: busy=%b rdy=%b, want 0 1", busy, req_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    a = 8'hAB; b = 8'hCD; cin = 1'b1; sub = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || req_ready !== 1'b1 ||
        cout !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun_reset: vld=%b busy=%b sum=%h rdy=%b cout=%b ovf=%b, want 0 0 00 1 0 0",
               res_valid, busy, sum, req_ready, cout, ovf);
    end
    do_op("after_reset", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
  endtask

  task automatic test_width1();
    int lat;
    tests_run++;
    if (w1_req_ready !== 1'b1 || w1_res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL w1_idle: rdy=%b vld=%b, want 1 0", w1_req_ready, w1_res_valid);
    end
    w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1; w1_sub = 1'b0; w1_req_valid = 1'b1;
    tick();
    w1_req_valid = 1'b0;
    lat = 0;
    while (w1_res_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    tests_run++;
    if (lat != 1) begin
      tests_failed++;
      $display("FAIL w1_latency: %0d clks, want 1", lat);
    end
    tests_run++;
    if (w1_sum !== 1'b1 || w1_cout !== 1'b1 || w1_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL w1_result: sum=%b cout=%b ovf=%b, want 1 1 0", w1_sum, w1_cout, w1_ovf);
    end
    w1_res_ready = 1'b1;
    tick();
    w1_res_ready = 1'b0;
    tests_run++;
    if (w1_req_ready !== 1'b1 || w1_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL w1_release: rdy=%b busy=%b, want 1 0", w1_req_ready, w1_busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
